// File: rtl/pio_port_ctrl.sv
// pio_port_ctrl
// Avalon-MM parallel I/O peripheral with two banks:
//   - an input bank that is synchronised, debounced and edge-captured, and that
//     drives a level interrupt through a mask
//   - an output register with plain, set-bit and clear-bit write access
//
// Ports
//   clk_clk        system clock, rising edge
//   reset_reset    asynchronous active-high reset
//   avs_address    word address (0 IN, 1 OUT, 2 OUT_SET, 3 OUT_CLR,
//                  4 IRQ_MASK, 5 EDGE, 6/7 unused)
//   avs_read       read strobe; avs_readdata is valid on the next cycle
//   avs_write      write strobe; the write takes effect on the sampling edge
//   avs_writedata  write data; bits above the register width are ignored
//   avs_readdata   registered read data, zero-extended
//   irq            registered level interrupt, |(EDGE & IRQ_MASK)
//   pio_in         raw asynchronous pin inputs
//   pio_out        output register
module pio_port_ctrl #(
    parameter int               IN_W            = 18,
    parameter int               OUT_W           = 18,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               EDGE_MODE       = 0,
    parameter logic [OUT_W-1:0] OUT_RESET       = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [IN_W-1:0]  pio_in,
    output logic [OUT_W-1:0] pio_out
);

    // Counter must hold 0..DEBOUNCE_CYCLES; keep at least one bit when bypassed.
    localparam int CNT_W = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (DEBOUNCE_CYCLES == 0) ? '0 : CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_IN      = 3'd0;
    localparam logic [2:0] ADDR_OUT     = 3'd1;
    localparam logic [2:0] ADDR_OUT_SET = 3'd2;
    localparam logic [2:0] ADDR_OUT_CLR = 3'd3;
    localparam logic [2:0] ADDR_MASK    = 3'd4;
    localparam logic [2:0] ADDR_EDGE    = 3'd5;

    logic [IN_W-1:0]  sync1_q;
    logic [IN_W-1:0]  sync_q;
    logic [IN_W-1:0]  deb_q, deb_d;
    logic [IN_W-1:0]  deb_dly_q;
    logic [CNT_W-1:0] cnt_q [IN_W];
    logic [CNT_W-1:0] cnt_d [IN_W];
    logic [OUT_W-1:0] out_q, out_d;
    logic [IN_W-1:0]  mask_q, mask_d;
    logic [IN_W-1:0]  edge_q, edge_d;
    logic [IN_W-1:0]  edge_det;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic [OUT_W-1:0] wd_out;
    logic [IN_W-1:0]  wd_in;
    logic             unused_wd;

    assign wd_out    = avs_writedata[OUT_W-1:0];
    assign wd_in     = avs_writedata[IN_W-1:0];
    assign unused_wd = ^avs_writedata;

    // Debounce: deb follows sync only after DEBOUNCE_CYCLES consecutive
    // mismatching cycles; any agreement restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < IN_W; i++) begin
            cnt_d[i] = '0;
            if (DEBOUNCE_CYCLES == 0) begin
                deb_d[i] = sync_q[i];
            end else if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        if (EDGE_MODE == 0) begin
            edge_det = deb_q & ~deb_dly_q;
        end else if (EDGE_MODE == 1) begin
            edge_det = ~deb_q & deb_dly_q;
        end else begin
            edge_det = deb_q ^ deb_dly_q;
        end
    end

    // Register writes; an edge seen in the same cycle as its W1C wins.
    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        edge_d = edge_q;
        if (avs_write) begin
            case (avs_address)
                ADDR_OUT:     out_d  = wd_out;
                ADDR_OUT_SET: out_d  = out_q | wd_out;
                ADDR_OUT_CLR: out_d  = out_q & ~wd_out;
                ADDR_MASK:    mask_d = wd_in;
                ADDR_EDGE:    edge_d = edge_q & ~wd_in;
                default:      ;
            endcase
        end
        edge_d = edge_d | edge_det;
    end

    // Read mux uses current register values, so a simultaneous write is not
    // visible in the returned data.
    always_comb begin
        rdata_d = '0;
        if (avs_read) begin
            case (avs_address)
                ADDR_IN:   rdata_d = 32'(deb_q);
                ADDR_OUT:  rdata_d = 32'(out_q);
                ADDR_MASK: rdata_d = 32'(mask_q);
                ADDR_EDGE: rdata_d = 32'(edge_q);
                default:   rdata_d = '0;
            endcase
        end
    end

    assign irq_d = |(edge_q & mask_q);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1_q   <= '0;
            sync_q    <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < IN_W; i++) begin
                cnt_q[i] <= '0;
            end
            out_q     <= OUT_RESET;
            mask_q    <= '0;
            edge_q    <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync1_q   <= pio_in;
            sync_q    <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            for (int i = 0; i < IN_W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out_q     <= out_d;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    assign pio_out      = out_q;

endmodule

// File: tb/tb_pio_port_ctrl.sv
module tb_pio_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  rd_v;
    logic [2:0]  wr_v;
    logic [31:0] rdata_v [3];
    logic [2:0]  irq_v;
    logic [17:0] in_m, in_e;
    logic [2:0]  in_b;
    logic [17:0] out_m, out_e, out_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] exp;
        int          sel;
        string       tag;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    rd_exp_t e_cur;
    logic    pend = 1'b0;

    always #5 clk = ~clk;

    // main: default widths, 16-cycle debounce, rising edges
    pio_port_ctrl #(.IN_W(18), .OUT_W(18), .DEBOUNCE_CYCLES(16), .EDGE_MODE(0),
                    .OUT_RESET(18'h00A5)) u_main (
        .clk_clk(clk), .reset_reset(rst), .avs_address(addr), .avs_read(rd_v[0]),
        .avs_write(wr_v[0]), .avs_writedata(wdata), .avs_readdata(rdata_v[0]),
        .irq(irq_v[0]), .pio_in(in_m), .pio_out(out_m));

    // either-edge instance with short debounce
    pio_port_ctrl #(.IN_W(18), .OUT_W(18), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2),
                    .OUT_RESET(18'h0)) u_either (
        .clk_clk(clk), .reset_reset(rst), .avs_address(addr), .avs_read(rd_v[1]),
        .avs_write(wr_v[1]), .avs_writedata(wdata), .avs_readdata(rdata_v[1]),
        .irq(irq_v[1]), .pio_in(in_e), .pio_out(out_e));

    // narrow instance with debounce bypassed
    pio_port_ctrl #(.IN_W(3), .OUT_W(18), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0),
                    .OUT_RESET(18'h0)) u_byp (
        .clk_clk(clk), .reset_reset(rst), .avs_address(addr), .avs_read(rd_v[2]),
        .avs_write(wr_v[2]), .avs_writedata(wdata), .avs_readdata(rdata_v[2]),
        .irq(irq_v[2]), .pio_in(in_b), .pio_out(out_b));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input int s, input logic [2:0] a, input logic [31:0] d);
        addr    = a;
        wdata   = d;
        wr_v    = '0;
        wr_v[s] = 1'b1;
        @(negedge clk);
        wr_v    = '0;
    endtask

    task automatic bus_read(input int s, input logic [2:0] a, input logic [31:0] exp,
                            input string tag);
        rd_exp_t r;
        r.exp = exp;
        r.sel = s;
        r.tag = tag;
        sb_q.push_back(r);
        addr    = a;
        rd_v    = '0;
        rd_v[s] = 1'b1;
        @(negedge clk);
        rd_v    = '0;
    endtask

    task automatic bus_rdwr(input int s, input logic [2:0] a, input logic [31:0] d,
                            input logic [31:0] exp, input string tag);
        rd_exp_t r;
        r.exp = exp;
        r.sel = s;
        r.tag = tag;
        sb_q.push_back(r);
        addr    = a;
        wdata   = d;
        rd_v    = '0;
        wr_v    = '0;
        rd_v[s] = 1'b1;
        wr_v[s] = 1'b1;
        @(negedge clk);
        rd_v    = '0;
        wr_v    = '0;
    endtask

    // Read data is due one cycle after the strobe is sampled.
    always @(posedge clk) pend <= |rd_v;

    always @(negedge clk) begin
        if (pend) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e_cur = sb_q.pop_front();
                chk(e_cur.tag, rdata_v[e_cur.sel], e_cur.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        addr  = '0;
        wdata = '0;
        rd_v  = '0;
        wr_v  = '0;
        in_m  = '0;
        in_e  = '0;
        in_b  = '0;
        idle(3);
        rst = 1'b0;
        idle(2);

        // mid-cycle reset with live state and read data in flight
        bus_write(0, 3'd1, 32'h0003_FFFF);
        bus_write(0, 3'd4, 32'h0000_0003);
        bus_read(0, 3'd1, 32'h0003_FFFF, "pre_rst_out");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pio_out", 32'(out_m), 32'h0000_00A5);
        chk("rst_rdata", rdata_v[0], 32'h0);
        chk("rst_irq", 32'(irq_v[0]), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        for (int a = 0; a < 8; a++) begin
            bus_read(0, 3'(a), (a == 1) ? 32'h0000_00A5 : 32'h0, $sformatf("rst_reg%0d", a));
        end

        // output register access
        bus_write(0, 3'd1, 32'hFFFF_FFFF);
        bus_read(0, 3'd1, 32'h0003_FFFF, "out_width");
        bus_write(0, 3'd1, 32'h0000_000F);
        bus_write(0, 3'd2, 32'h0000_0030);
        bus_write(0, 3'd3, 32'h0000_0003);
        chk("out_setclr_pin", 32'(out_m), 32'h0000_003C);
        bus_read(0, 3'd1, 32'h0000_003C, "out_read");
        bus_read(0, 3'd2, 32'h0, "out_set_rd");
        bus_read(0, 3'd3, 32'h0, "out_clr_rd");
        bus_rdwr(0, 3'd1, 32'h0000_0155, 32'h0000_003C, "rdwr_old");
        chk("rdwr_pin", 32'(out_m), 32'h0000_0155);
        bus_read(0, 3'd1, 32'h0000_0155, "rdwr_new");

        // short glitch must be rejected
        bus_write(0, 3'd4, 32'h0000_0001);
        in_m[0] = 1'b1;
        idle(10);
        in_m[0] = 1'b0;
        idle(25);
        bus_read(0, 3'd0, 32'h0, "glitch_in");
        bus_read(0, 3'd5, 32'h0, "glitch_edge");
        chk("glitch_irq", 32'(irq_v[0]), 32'h0);

        // held input: IN at 18 cycles, EDGE one later, irq one after that
        in_m[0] = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            bus_read(0, 3'd0, (k >= 19) ? 32'h1 : 32'h0, $sformatf("deb_in_c%0d", k));
            chk($sformatf("deb_irq_c%0d", k), 32'(irq_v[0]), (k >= 20) ? 32'h1 : 32'h0);
        end
        bus_read(0, 3'd5, 32'h1, "deb_edge");
        bus_write(0, 3'd4, 32'h0);
        bus_write(0, 3'd5, 32'h1);
        bus_read(0, 3'd5, 32'h0, "deb_edge_clr");

        // masking, bit 2
        in_m[2] = 1'b1;
        idle(25);
        bus_read(0, 3'd5, 32'h4, "msk_edge");
        chk("msk_irq_off", 32'(irq_v[0]), 32'h0);
        bus_write(0, 3'd4, 32'h4);
        chk("msk_irq_lat", 32'(irq_v[0]), 32'h0);
        idle(1);
        chk("msk_irq_on", 32'(irq_v[0]), 32'h1);
        bus_write(0, 3'd4, 32'h0);
        idle(1);
        chk("msk_irq_masked", 32'(irq_v[0]), 32'h0);
        bus_read(0, 3'd5, 32'h4, "msk_edge_kept");
        bus_write(0, 3'd4, 32'h4);
        idle(1);
        chk("msk_irq_again", 32'(irq_v[0]), 32'h1);
        bus_write(0, 3'd5, 32'h4);
        chk("w1c_irq_lat", 32'(irq_v[0]), 32'h1);
        idle(1);
        chk("w1c_irq_off", 32'(irq_v[0]), 32'h0);
        bus_read(0, 3'd5, 32'h0, "w1c_edge");

        // either-edge: falling edge lands in the same cycle as W1C
        in_e[1] = 1'b1;
        idle(15);
        bus_read(1, 3'd5, 32'h2, "either_rise");
        bus_write(1, 3'd5, 32'h2);
        bus_read(1, 3'd5, 32'h0, "either_clr");
        in_e[1] = 1'b0;
        idle(6);
        bus_write(1, 3'd5, 32'h2);
        bus_read(1, 3'd5, 32'h2, "edge_wins");
        bus_read(1, 3'd0, 32'h0, "either_in");
        bus_write(1, 3'd5, 32'h2);
        bus_read(1, 3'd5, 32'h0, "edge_clr2");

        // bypass, 3-bit input
        in_b = 3'b101;
        idle(2);
        bus_read(2, 3'd0, 32'h0, "byp_in_early");
        bus_read(2, 3'd0, 32'h5, "byp_in");
        idle(2);
        bus_read(2, 3'd5, 32'h5, "byp_edge");
        bus_write(2, 3'd4, 32'hFFFF_FFFF);
        bus_read(2, 3'd4, 32'h7, "byp_mask");
        bus_write(2, 3'd7, 32'hFFFF_FFFF);
        bus_write(2, 3'd6, 32'hFFFF_FFFF);
        bus_read(2, 3'd0, 32'h5, "a7_in");
        bus_read(2, 3'd1, 32'h0, "a7_out");
        bus_read(2, 3'd4, 32'h7, "a7_mask");
        bus_read(2, 3'd5, 32'h5, "a7_edge");
        chk("a7_pin", 32'(out_b), 32'h0);
        chk("a7_irq", 32'(irq_v[2]), 32'h1);

        idle(3);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
